// File: rtl/frag_pkg.sv
// Shared types and constants for the sequential barycentric fragment shader.
//   state_t     : sequencer states (IDLE, DIV, DONE)
//   CW          : iteration counter width for the default QW
//   BG_DEFAULT  : default background colour {B,G,R} for QW=4
//   cnt_width() : counter width helper for any QW (minimum 1 bit)
package frag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned QW_DEF = 4;
  localparam int unsigned CW     = $clog2(QW_DEF);

  localparam logic [3*QW_DEF-1:0] BG_DEFAULT = {4'h7, 4'h3, 4'h1};

  // Counter width that stays legal even for a single-iteration divider.
  function automatic int unsigned cnt_width(input int unsigned qw);
    return (qw > 1) ? $clog2(qw) : 1;
  endfunction

endpackage

// File: rtl/frag_div_lane.sv
// One channel of the radix-2 restoring divider.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   i_load          : capture numerator and saturation flag
//   i_step          : perform one quotient-bit iteration
//   i_num           : numerator (sampled on i_load)
//   i_load_den      : denominator used for the saturation test at load
//   i_den           : registered shared denominator used while stepping
//   o_q_next_c      : quotient after the current step (combinational)
//   o_sat           : registered saturation flag (num >= den, den != 0)
module frag_div_lane
  import frag_pkg::*;
#(
  parameter int unsigned W  = 20,
  parameter int unsigned QW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [W-1:0]  i_num,
  input  logic [W-1:0]  i_load_den,
  input  logic [W-1:0]  i_den,
  output logic [QW-1:0] o_q_next_c,
  output logic          o_sat
);

  logic [W:0]    r_rem;
  logic [QW-1:0] r_q;
  logic          r_sat;

  logic [W:0]    w_t;
  logic          w_ge;
  logic [W:0]    w_rem_next;
  logic [QW-1:0] w_q_next;

  // Trial subtraction; rem stays below den on the unsaturated path so t fits W+1 bits.
  always_comb begin
    w_t        = {r_rem[W-1:0], 1'b0};
    w_ge       = (w_t >= {1'b0, i_den});
    w_rem_next = w_ge ? (w_t - {1'b0, i_den}) : w_t;
    w_q_next   = (r_q << 1) | QW'(w_ge);
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_q   <= '0;
      r_sat <= 1'b0;
    end else if (i_load) begin
      r_rem <= {1'b0, i_num};
      r_q   <= '0;
      r_sat <= (i_load_den != '0) && (i_num >= i_load_den);
    end else if (i_step) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
    end
  end

  assign o_q_next_c = w_q_next;
  assign o_sat      = r_sat;

endmodule

// File: rtl/frag_shader_seq.sv
// Sequential barycentric fragment shader: per channel floor(num*2^QW/den),
// saturated, one quotient bit per cycle, valid/ready on both sides.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (ready only in IDLE)
//   in_visible          : pixel inside triangle; else background is output
//   in_num [CH*W]       : packed numerators, channel c at [c*W +: W]
//   in_den [W]          : shared denominator (triangle area)
//   bg_color [CH*QW]    : background colour, sampled at accept
//   out_valid/out_ready : output handshake
//   out_color [CH*QW]   : packed result, channel c at [c*QW +: QW]
module frag_shader_seq
  import frag_pkg::*;
#(
  parameter int unsigned W  = 20,
  parameter int unsigned QW = 4,
  parameter int unsigned CH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_visible,
  input  logic [CH*W-1:0] in_num,
  input  logic [W-1:0]    in_den,
  input  logic [CH*QW-1:0] bg_color,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*QW-1:0] out_color
);

  localparam int unsigned CNT_W = cnt_width(QW);

  state_t          r_state;
  state_t          w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]    r_den;
  logic [CH*QW-1:0] r_out_color;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [CH*QW-1:0] w_div_color;

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (!in_visible || (in_den == '0)) ? DONE : DIV;
        end
      end
      DIV: begin
        w_step = 1'b1;
        // The step taken while the counter reads 0 produces the final bit.
        if (r_cnt == '0) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Sequencer, counter, shared denominator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_den       <= '0;
      r_out_color <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next == DONE);
      if (w_accept) begin
        r_cnt <= CNT_W'(QW - 1);
        r_den <= in_den;
        if (!in_visible) begin
          r_out_color <= bg_color;
        end else if (in_den == '0) begin
          r_out_color <= {(CH*QW){1'b1}};
        end
      end else if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_out_color <= w_div_color;
        end
      end
    end
  end

  // Lockstep divider lanes, one per channel.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [QW-1:0] w_q_next;
    logic          w_sat;

    frag_div_lane #(
      .W  (W),
      .QW (QW)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_step     (w_step),
      .i_num      (in_num[c*W +: W]),
      .i_load_den (in_den),
      .i_den      (r_den),
      .o_q_next_c (w_q_next),
      .o_sat      (w_sat)
    );

    assign w_div_color[c*QW +: QW] = w_sat ? {QW{1'b1}} : w_q_next;
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_color = r_out_color;

endmodule

// File: tb/tb_frag_shader_seq.sv
// Self-checking bench for frag_shader_seq: directed scenarios plus randomized
// transactions checked against an arithmetic reference model.
module tb_frag_shader_seq;

  localparam int unsigned W  = 20;
  localparam int unsigned QW = 4;
  localparam int unsigned CH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_visible;
  logic [CH*W-1:0]  in_num;
  logic [W-1:0]     in_den;
  logic [CH*QW-1:0] bg_color;
  logic             out_valid;
  logic             out_ready;
  logic [CH*QW-1:0] out_color;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;

  frag_shader_seq #(.W(W), .QW(QW), .CH(CH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_visible (in_visible),
    .in_num     (in_num),
    .in_den     (in_den),
    .bg_color   (bg_color),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_color  (out_color)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pk_num(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [CH*QW-1:0] pk_col(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    return {QW'(c), QW'(b), QW'(a)};
  endfunction

  // Reference: colour = floor(num * 2^QW / den), clamped to all-ones.
  function automatic logic [CH*QW-1:0] model(input logic [CH*W-1:0] num, input logic [W-1:0] den,
                                             input logic vis, input logic [CH*QW-1:0] bg);
    logic [CH*QW-1:0] r;
    longint unsigned  n, q, maxv;
    r    = '0;
    maxv = (64'd1 << QW) - 1;
    if (!vis) return bg;
    if (den == 0) return {(CH*QW){1'b1}};
    for (int c = 0; c < CH; c++) begin
      n = longint'(num[c*W +: W]);
      q = (n * (64'd1 << QW)) / longint'(den);
      if (q > maxv) q = maxv;
      r[c*QW +: QW] = QW'(q);
    end
    return r;
  endfunction

  // One full transaction; hold = cycles to stall out_ready once the result appears.
  task automatic run_txn(input string tag, input logic [CH*W-1:0] num, input logic [W-1:0] den,
                         input logic vis, input logic [CH*QW-1:0] bg, input int exp_lat,
                         input int hold);
    logic [CH*QW-1:0] exp_col;
    int lat;
    exp_col   = model(num, den, vis, bg);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_num    = num;
    in_den    = den;
    in_visible = vis;
    bg_color  = bg;
    chk({tag, ".ready_idle"}, 64'(in_ready), 64'd1);
    step();
    last_acc  = cyc;
    in_valid  = 1'b0;
    in_num    = CH*W'({$urandom, $urandom});
    in_den    = W'($urandom);
    in_visible = 1'($urandom);
    bg_color  = CH*QW'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) chk({tag, ".ready_busy"}, 64'(in_ready), 64'd0);
      step();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".color"}, 64'(out_color), 64'(exp_col));
    chk({tag, ".ready_done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_num   = CH*W'({$urandom, $urandom});
      in_den   = W'($urandom);
      step();
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_color"}, 64'(out_color), 64'(exp_col));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, ".drained"}, 64'(out_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [CH*W-1:0]  rn;
    logic [W-1:0]     rd;
    logic             rv;
    int               prev;
    int unsigned      top;

    rst_n = 1'b0; in_valid = 1'b0; in_visible = 1'b0; in_num = '0; in_den = '0;
    bg_color = '0; out_ready = 1'b1;
    step(); step();
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.out_color", 64'(out_color), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // 1 and 2: divide path, including a saturated channel.
    run_txn("t1", pk_num(500, 250, 0), 20'd1000, 1'b1, '0, QW + 1, 0);
    chk("t1.const", 64'(model(pk_num(500, 250, 0), 20'd1000, 1'b1, '0)), 64'(pk_col(8, 4, 0)));
    run_txn("t2", pk_num(999, 937, 1000), 20'd1000, 1'b1, '0, QW + 1, 0);
    chk("t2.color_abs", 64'(out_color), 64'(pk_col(15, 14, 15)));

    // 3: background and zero-area fast paths.
    run_txn("t3bg", pk_num(11, 22, 33), 20'd77, 1'b0, pk_col(1, 3, 7), 1, 0);
    chk("t3bg.color_abs", 64'(out_color), 64'(pk_col(1, 3, 7)));
    run_txn("t3den0", pk_num(5, 6, 7), 20'd0, 1'b1, pk_col(1, 3, 7), 1, 0);
    chk("t3den0.color_abs", 64'(out_color), 64'(pk_col(15, 15, 15)));

    // 4: downstream stall in DONE, then next accept right after the handshake.
    run_txn("t4", pk_num(300, 600, 900), 20'd1000, 1'b1, '0, QW + 1, 10);
    prev = cyc;
    run_txn("t4next", pk_num(1, 2, 3), 20'd4, 1'b1, '0, QW + 1, 0);
    chk("t4.next_accept_gap", 64'(last_acc - prev), 64'd1);

    // 5: reset during DIV aborts the transaction.
    in_valid = 1'b1; in_visible = 1'b1; in_num = pk_num(700, 800, 900); in_den = 20'd1000;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("t5.rst_out_valid", 64'(out_valid), 64'd0);
    chk("t5.rst_out_color", 64'(out_color), 64'd0);
    chk("t5.rst_in_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    run_txn("t5post", pk_num(1, 2, 3), 20'd4, 1'b1, '0, QW + 1, 0);
    chk("t5post.color_abs", 64'(out_color), 64'(pk_col(4, 8, 12)));

    // 6: full width and back-to-back throughput.
    run_txn("t6a", pk_num(20'hFFFFE, 20'hFFFFE, 20'hFFFFE), 20'hFFFFF, 1'b1, '0, QW + 1, 0);
    chk("t6a.color_abs", 64'(out_color), 64'(pk_col(15, 15, 15)));
    prev = last_acc;
    run_txn("t6b", pk_num(20'hFFFFE, 1, 20'h80000), 20'hFFFFF, 1'b1, '0, QW + 1, 0);
    chk("t6.period", 64'(last_acc - prev), 64'(QW + 2));

    // Randomized transactions against the model.
    for (int k = 0; k < 40; k++) begin
      rv = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) rd = '0;
      else if ($urandom_range(0, 1) == 0) rd = W'($urandom_range(1, 64));
      else rd = W'($urandom_range(1, (1 << W) - 1));
      top = int'(rd) + int'(rd) / 8 + 1;
      if (top > (1 << W) - 1) top = (1 << W) - 1;
      for (int c = 0; c < CH; c++) rn[c*W +: W] = W'($urandom_range(0, top));
      run_txn("rand", rn, rd, rv, CH*QW'($urandom),
              (!rv || rd == '0) ? 1 : QW + 1, (k % 5 == 0) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frag_shader_seq.md
Name: frag_shader_seq

Overview:
Sequential, parametrised successor to the combinational barycentric fragment shader. It takes CH barycentric area numerators and one shared triangle area, and computes one QW-bit colour component per channel: floor(num*2^QW/den), saturated. Division is radix-2 restoring, one quotient bit per cycle. A valid/ready handshake sits on both input and output, so the block fits between the rasteriser edge-function stage and the pixel write path without a wide combinational comparator tree.

Parameters:
W, 20, width of each numerator and of the shared denominator.
QW, 4, quotient (colour component) width; iteration count.
CH, 3, number of channels (R,G,B by default).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input transaction present.
in_ready  out  1  block can accept; high only in IDLE.
in_visible  in  1  pixel inside triangle.
in_num  in  CH*W  packed numerators; channel c at bits [c*W +: W].
in_den  in  W  shared denominator (triangle area).
bg_color  in  CH*QW  background colour used when in_visible=0; sampled at accept.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts result.
out_color  out  CH*QW  packed result; channel c at bits [c*QW +: QW].

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_color=0, all lane registers 0.
- FSM states: IDLE, DIV, DONE.
- IDLE: in_ready=1. The accept edge is in_valid&&in_ready. Capture num, den, visible and bg_color at that edge.
  - visible=0 -> DONE with out_color=bg_color.
  - visible=1, den=0 -> DONE with every channel all-ones.
  - otherwise -> DIV, iteration counter = QW-1.
- Per-channel saturation flag is set at accept when num>=den (den!=0). A saturated channel outputs all-ones regardless of iteration result.
- DIV, per lane: rem is W+1 bits, initialised to num. Each cycle:
  - t = rem<<1;
  - if t>=den then rem=t-den, qbit=1; else rem=t, qbit=0.
  - The quotient shifts left with qbit in the LSB.
  - All CH lanes step in lockstep.
  - Counter decrements; when it reaches 0 -> DONE.
- DONE: out_valid=1. out_color is registered and held stable until out_valid&&out_ready, then -> IDLE. No new input is accepted in the same edge (in_ready=0 in DONE).
- Latency, from accept edge to out_valid high:
  - QW+1 edges on the divide path;
  - 1 edge on the background or den=0 path.
- Throughput: one pixel per QW+2 cycles with out_ready held high.
- out_valid must not drop and out_color must not change while out_ready=0.
- in_ready is combinational from state: low during DIV and DONE.
- Inputs are ignored outside the accept edge; changing in_num mid-DIV has no effect.
- Reset mid-DIV or mid-DONE aborts the transaction with no output. The first transaction after release behaves as from cold reset.
- Widths: all comparisons are unsigned at W+1 bits; no truncation of rem.

Decomposition:
- Package frag_pkg:
  - state enum {IDLE, DIV, DONE};
  - default background constant {4'h7,4'h3,4'h1} for QW=4;
  - localparam CW=$clog2(QW) for the iteration counter.
- Sub-module frag_div_lane: one channel's rem/quotient/saturation registers with load/step controls. It is instantiated CH times by a generate loop. The FSM and counter live in frag_shader_seq.

Test Plan:
1. W=20, QW=4, den=1000, visible, num=(500,250,0) -> out_color channels (8,4,0); out_valid exactly 5 edges after accept; in_ready low throughout.
2. den=1000, num=(999,937,1000) -> (15,14,15); 1000 exercises the saturate flag.
3. visible=0, bg_color=(1,3,7), arbitrary num/den -> (1,3,7) one edge after accept. visible=1, den=0 -> (15,15,15) one edge after accept.
4. out_ready held low 10 cycles in DONE -> out_valid and out_color stable, in_valid pulses not accepted. Release -> handshake completes, next accept 1 cycle later.
5. Assert rst_n low during DIV cycle 2 -> out_valid=0, out_color=0, in_ready=1 immediately. Next transaction num=(1,2,3), den=4 -> (4,8,12) with normal latency.
6. Maximal width, den=2^20-1, num=2^20-2 on all channels -> 15. Back-to-back transactions with out_ready=1 -> one result every 6 cycles.
